// File: rtl/ysyx_23060025_axi_rd_sram.sv
`default_nettype none
// ============================================================================
// ysyx_23060025_axi_rd_sram : AXI4 read-burst responder over a preloadable word memory
// Revision 1.0
// ============================================================================
module ysyx_23060025_axi_rd_sram #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH_W = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    LATENCY     = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ld_en,
  input  logic [MEM_DEPTH_W-1:0] ld_idx,
  input  logic [DATA_WIDTH-1:0]  ld_data,
  input  logic [ADDR_WIDTH-1:0]  in_araddr,
  input  logic                   in_arvalid,
  output logic                   in_arready,
  input  logic [7:0]             in_arlen,
  input  logic [2:0]             in_arsize,
  input  logic [1:0]             in_arburst,
  output logic                   in_rvalid,
  input  logic                   in_rready,
  output logic [DATA_WIDTH-1:0]  in_rdata,
  output logic [1:0]             in_rresp,
  output logic                   in_rlast
);

  localparam int              c_DEPTH  = 1 << MEM_DEPTH_W;
  localparam logic [3:0]      c_LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [1:0]      c_OKAY   = 2'b00;
  localparam logic [1:0]      c_SLVERR = 2'b10;
  localparam logic [1:0]      c_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_BEAT = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [DATA_WIDTH-1:0]   r_mem [0:c_DEPTH-1];

  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_len;
  logic [1:0]              r_burst;
  logic                    r_bad;
  logic [7:0]              r_beat_cnt;
  logic [3:0]              r_wait_cnt;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_rresp;
  logic                    r_rlast;

  logic                    w_capture;
  logic                    w_launch;
  logic                    w_accept;
  logic                    w_ar_bad;
  logic [ADDR_WIDTH-1:0]   w_addr_inc;
  logic [ADDR_WIDTH-1:0]   w_wrap_mask;
  logic [ADDR_WIDTH-1:0]   w_next_addr;
  logic [ADDR_WIDTH-1:0]   w_src_addr;
  logic                    w_src_bad;
  logic [7:0]              w_src_cnt;
  logic [ADDR_WIDTH-1:0]   w_off;
  logic                    w_in_range;
  logic [MEM_DEPTH_W-1:0]  w_idx;
  logic [DATA_WIDTH-1:0]   w_beat_data;
  logic [1:0]              w_beat_resp;

  // Preload port is independent of the burst engine and never reset.
  always_ff @(posedge clock) begin
    if (ld_en) begin
      r_mem[ld_idx] <= ld_data;
    end
  end

  assign w_ar_bad = (in_arsize != 3'b010) || (in_arburst == 2'b11) ||
                    ((in_arburst == 2'b10) &&
                     !((in_arlen == 8'd1) || (in_arlen == 8'd3) ||
                       (in_arlen == 8'd7) || (in_arlen == 8'd15)));

  assign w_addr_inc  = r_addr + ADDR_WIDTH'(4);
  assign w_wrap_mask = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << 2) - ADDR_WIDTH'(1);

  always_comb begin
    w_next_addr = w_addr_inc;
    case (r_burst)
      2'b00:   w_next_addr = r_addr;
      2'b10:   w_next_addr = (r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
      default: w_next_addr = w_addr_inc;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_launch     = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_arvalid) begin
          w_capture = 1'b1;
          if (LATENCY == 0) begin
            w_state_next = S_BEAT;
            w_launch     = 1'b1;
          end else begin
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_state_next = S_BEAT;
          w_launch     = 1'b1;
        end
      end
      S_BEAT: begin
        if (in_rready) begin
          w_accept = 1'b1;
          if (r_beat_cnt == 8'd0) begin
            w_state_next = S_IDLE;
          end else begin
            w_launch = 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // The beat being launched comes straight from AR, from the held address, or from the advanced address.
  always_comb begin
    w_src_addr = r_addr;
    w_src_bad  = r_bad;
    w_src_cnt  = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        w_src_addr = in_araddr;
        w_src_bad  = w_ar_bad;
        w_src_cnt  = in_arlen;
      end
      S_BEAT: begin
        w_src_addr = w_next_addr;
        w_src_cnt  = r_beat_cnt - 8'd1;
      end
      default: begin
        w_src_addr = r_addr;
      end
    endcase
  end

  assign w_off       = w_src_addr - BASE_ADDR;
  assign w_in_range  = (w_off >> (MEM_DEPTH_W + 2)) == '0;
  assign w_idx       = w_off[MEM_DEPTH_W+1:2];

  always_comb begin
    w_beat_data = '0;
    w_beat_resp = c_OKAY;
    if (w_src_bad) begin
      w_beat_resp = c_SLVERR;
    end else if (!w_in_range) begin
      w_beat_resp = c_DECERR;
    end else begin
      w_beat_data = r_mem[w_idx];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_burst    <= '0;
      r_bad      <= 1'b0;
      r_beat_cnt <= '0;
      r_wait_cnt <= '0;
      r_rdata    <= '0;
      r_rresp    <= c_OKAY;
      r_rlast    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr     <= in_araddr;
        r_len      <= in_arlen;
        r_burst    <= in_arburst;
        r_bad      <= w_ar_bad;
        r_beat_cnt <= in_arlen;
        r_wait_cnt <= c_LAT_M1;
      end
      if ((r_state == S_WAIT) && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (w_accept && (r_beat_cnt != 8'd0)) begin
        r_beat_cnt <= r_beat_cnt - 8'd1;
        r_addr     <= w_next_addr;
      end
      if (w_launch) begin
        r_rdata <= w_beat_data;
        r_rresp <= w_beat_resp;
        r_rlast <= (w_src_cnt == 8'd0);
      end
    end
  end

  assign in_arready = (r_state == S_IDLE);
  assign in_rvalid  = (r_state == S_BEAT);
  assign in_rdata   = r_rdata;
  assign in_rresp   = r_rresp;
  assign in_rlast   = r_rlast;

endmodule
`default_nettype wire
